// File: rtl/userio_osd_cmd_if.sv
// Byte-level link between the OSD SPI slave, the command decoder and the OSD
// character buffer write port.
interface userio_osd_cmd_if #(
  parameter int ROWS_LOG2 = 4
);
  logic [7:0]           spi_dat;
  logic                 spi_rx;
  logic                 spi_cmd;
  logic                 spi_vld;
  logic [7:0]           spi_in;
  logic                 buf_wr;
  logic [ROWS_LOG2+7:0] buf_addr;
  logic [7:0]           buf_dat;

  // master: the SPI slave / buffer side; slave: the command decoder
  modport master (
    output spi_dat, spi_rx, spi_cmd, spi_vld,
    input  spi_in, buf_wr, buf_addr, buf_dat
  );

  modport slave (
    input  spi_dat, spi_rx, spi_cmd, spi_vld,
    output spi_in, buf_wr, buf_addr, buf_dat
  );
endinterface

// File: rtl/userio_osd_cmd.sv
// OSD command decoder: one command per SPI transaction, auto-incrementing
// character-buffer writes, OSD enable and highlight registers.
module userio_osd_cmd #(
  parameter int ROWS_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  clk7_en,
  userio_osd_cmd_if.slave       bus,
  output logic                  osd_enable,
  output logic [3:0]            highlight
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WRROW  = 2'b01,
    HILITE = 2'b10,
    IGNORE = 2'b11
  } state_t;

  state_t               state;
  logic                 rx_d;
  logic [ROWS_LOG2-1:0] row;
  logic [7:0]           col;
  logic                 byte_evt;

  // One event per byte regardless of how long spi_rx stays high.
  assign byte_evt = bus.spi_rx && !rx_d;

  // NOTE: combinational from registers only, so the slave always latches the
  // status as of the current cycle; a continuous assign cannot infer a latch.
  assign bus.spi_in = {osd_enable, 3'b000, highlight};

  // NOTE: every register here uses non-blocking assignment so all updates
  // within one clk7_en edge see the pre-edge values of their neighbours.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      rx_d         <= 1'b0;
      row          <= '0;
      col          <= '0;
      bus.buf_wr   <= 1'b0;
      bus.buf_addr <= '0;
      bus.buf_dat  <= '0;
      osd_enable   <= 1'b0;
      highlight    <= '0;
    end else if (clk7_en) begin
      rx_d       <= bus.spi_rx;
      bus.buf_wr <= 1'b0;

      if (!bus.spi_vld) begin
        // End of transaction wins over a coincident byte event.
        state <= IDLE;
      end else if (byte_evt) begin
        if (bus.spi_cmd) begin
          casez (bus.spi_dat)
            8'b0000_0000: state <= IGNORE;
            8'b0010_????: begin
              row   <= ROWS_LOG2'(bus.spi_dat[3:0]);
              col   <= '0;
              state <= WRROW;
            end
            8'b0100_????: begin
              osd_enable <= bus.spi_dat[0];
              state      <= IGNORE;
            end
            8'b1000_0000: state <= HILITE;
            default:      state <= IGNORE;
          endcase
        end else begin
          case (state)
            WRROW: begin
              bus.buf_wr   <= 1'b1;
              bus.buf_addr <= {row, col};
              bus.buf_dat  <= bus.spi_dat;
              col          <= col + 8'd1;
            end
            HILITE: begin
              highlight <= bus.spi_dat[3:0];
              state     <= IGNORE;
            end
            IDLE, IGNORE: state <= state;
            default:      state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_userio_osd_cmd.sv
// Directed bench for userio_osd_cmd: expected buffer writes go into a queue
// that an independent monitor drains whenever the buffer would sample.
module tb_userio_osd_cmd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk7_en = 1'b0;
  logic       osd_enable;
  logic [3:0] highlight;

  int total = 0;
  int bad   = 0;
  int div   = 0;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  dat;
  } wr_t;

  wr_t exp_q[$];

  userio_osd_cmd_if #(.ROWS_LOG2(4)) bus ();

  userio_osd_cmd #(.ROWS_LOG2(4)) dut (
    .clk        (clk),
    ._reset     (rst_n),
    .clk7_en    (clk7_en),
    .bus        (bus),
    .osd_enable (osd_enable),
    .highlight  (highlight)
  );

  always #5 clk = ~clk;

  // clk7_en: one clk in four, changed just after the edge it no longer governs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      div     = (div + 1) % 4;
      clk7_en = (div == 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the buffer samples on a clk7_en edge while buf_wr=1.
  always @(negedge clk) begin
    if (rst_n && clk7_en && bus.buf_wr) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h dat %0h expected no write",
                 bus.buf_addr, bus.buf_dat);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.buf_addr), 32'(e.addr));
        check("wr_dat", 32'(bus.buf_dat), 32'(e.dat));
      end
    end
  end

  // Return at a negedge whose following posedge is a clk7_en edge.
  task automatic ce();
    @(negedge clk);
    while (!clk7_en) @(negedge clk);
  endtask

  task automatic send(input logic cmd, input logic [7:0] dat);
    bus.spi_cmd = cmd;
    bus.spi_dat = dat;
    bus.spi_rx  = 1'b1;
    ce();
    bus.spi_rx  = 1'b0;
    ce();
  endtask

  task automatic begin_tr();
    bus.spi_vld = 1'b1;
    ce();
  endtask

  task automatic end_tr();
    bus.spi_vld = 1'b0;
    ce();
    ce();
  endtask

  task automatic expect_wr(input logic [11:0] addr, input logic [7:0] dat);
    wr_t e;
    e.addr = addr;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.spi_dat = '0;
    bus.spi_rx  = 1'b0;
    bus.spi_cmd = 1'b0;
    bus.spi_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_spi_in", 32'(bus.spi_in), 32'h00);
    check("rst_buf_wr", 32'(bus.buf_wr), 32'h0);
    check("rst_buf_addr", 32'(bus.buf_addr), 32'h000);
    check("rst_buf_dat", 32'(bus.buf_dat), 32'h00);
    check("rst_osd_enable", 32'(osd_enable), 32'h0);
    check("rst_highlight", 32'(highlight), 32'h0);
    rst_n = 1'b1;
    ce();

    // Row 3 write with column wrap after 256 bytes.
    begin_tr();
    send(1'b1, 8'h23);
    expect_wr(12'h300, 8'hAA);
    send(1'b0, 8'hAA);
    expect_wr(12'h301, 8'hBB);
    send(1'b0, 8'hBB);
    for (int i = 2; i < 258; i++) begin
      logic [7:0] c;
      c = 8'(i);
      expect_wr({4'h3, c}, c ^ 8'h5A);
      send(1'b0, c ^ 8'h5A);
    end
    end_tr();
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // OSD enable on, then off in the next transaction.
    begin_tr();
    send(1'b1, 8'h41);
    check("osd_on", 32'(osd_enable), 32'h1);
    check("osd_on_spi_in", 32'(bus.spi_in), 32'h80);
    end_tr();
    begin_tr();
    send(1'b1, 8'h40);
    check("osd_off", 32'(osd_enable), 32'h0);
    end_tr();

    // A byte while chip select is inactive is ignored.
    send(1'b1, 8'h41);
    check("vld_low_ignored", 32'(osd_enable), 32'h0);
    ce();

    // Highlight: first data byte only.
    begin_tr();
    send(1'b1, 8'h80);
    send(1'b0, 8'h07);
    send(1'b0, 8'h0C);
    check("highlight", 32'(highlight), 32'h7);
    check("hl_spi_in", 32'(bus.spi_in), 32'h07);
    end_tr();

    // Abort: data after chip-select drop is dropped.
    begin_tr();
    send(1'b1, 8'h25);
    expect_wr(12'h500, 8'h11);
    send(1'b0, 8'h11);
    end_tr();
    begin_tr();
    send(1'b0, 8'h22);
    end_tr();
    check("abort_drained", 32'(exp_q.size()), 32'd0);

    // Preempt by a new WRITE_ROW, then an unknown command.
    begin_tr();
    send(1'b1, 8'h23);
    expect_wr(12'h300, 8'h01);
    send(1'b0, 8'h01);
    send(1'b1, 8'h21);
    expect_wr(12'h100, 8'h02);
    send(1'b0, 8'h02);
    send(1'b1, 8'hFF);
    send(1'b0, 8'h03);
    send(1'b0, 8'h04);
    end_tr();

    // Long spi_rx pulse gives a single event.
    begin_tr();
    send(1'b1, 8'h27);
    expect_wr(12'h700, 8'h99);
    bus.spi_cmd = 1'b0;
    bus.spi_dat = 8'h99;
    bus.spi_rx  = 1'b1;
    ce();
    ce();
    ce();
    bus.spi_rx = 1'b0;
    ce();
    end_tr();
    check("long_pulse_drained", 32'(exp_q.size()), 32'd0);

    // Load non-zero status, then reset in the middle of a write.
    begin_tr();
    send(1'b1, 8'h41);
    end_tr();
    begin_tr();
    send(1'b1, 8'h80);
    send(1'b0, 8'h05);
    check("status_pre_reset", 32'(bus.spi_in), 32'h85);
    end_tr();
    begin_tr();
    send(1'b1, 8'h26);
    expect_wr(12'h600, 8'h10);
    bus.spi_cmd = 1'b0;
    bus.spi_dat = 8'h10;
    bus.spi_rx  = 1'b1;
    ce();
    check("wr_before_reset", 32'(bus.buf_wr), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_buf_wr", 32'(bus.buf_wr), 32'h0);
    check("arst_buf_addr", 32'(bus.buf_addr), 32'h000);
    check("arst_buf_dat", 32'(bus.buf_dat), 32'h00);
    check("arst_osd_enable", 32'(osd_enable), 32'h0);
    check("arst_highlight", 32'(highlight), 32'h0);
    check("arst_spi_in", 32'(bus.spi_in), 32'h00);
    bus.spi_rx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ce();
    send(1'b0, 8'h33);
    send(1'b0, 8'h44);
    end_tr();
    begin_tr();
    send(1'b1, 8'h2A);
    expect_wr(12'hA00, 8'h55);
    send(1'b0, 8'h55);
    end_tr();

    repeat (4) ce();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
